pwm_servo_drive: RTL and testbench
==================================

// Module: pwm_servo_drive
// PURPOSE
//  Downstream stage of the IPD controller. Generates the controller's Rx_En sample request, captures
//  the signed control output Yk, and converts it to a saturated duty value. Drives a fixed-period
//  PWM line to the servo power stage. New duty values take effect only at PWM period boundaries.
// PARAMETERS
//  cant_bits   16    controller operand width; Yk is 2*cant_bits signed
//  CNT_W       16    PWM counter / duty width (unsigned)
//  PERIOD      1000  PWM period in Clk_G cycles (counter 0..PERIOD-1)
//  SAMPLE_DIV  10    PWM periods per controller sample (>=1)
//  RX_EN_CYC   8     cycles Rx_En is held high per request (>=6, RX_EN_CYC+2 < PERIOD)
//  SHIFT       4     arithmetic right shift applied to Yk
//  OFFSET      500   duty added after shift (servo centre)
//  DUTY_MIN    50    lower duty clamp (DUTY_MIN <= OFFSET <= DUTY_MAX <= PERIOD)
//  DUTY_MAX    950   upper duty clamp
// PORTS
//  Clk_G   in   1             system clock, rising edge
//  Rst_G   in   1             asynchronous reset, active-high
//  En      in   1             run enable; low = PWM idle, sequencer parked
//  Yk      in   2*cant_bits   signed controller output
//  Rx_En   out  1             sample request to controller (level, RX_EN_CYC cycles)
//  Pwm     out  1             registered PWM output
//  Duty    out  CNT_W         active duty value
//  Sat     out  1             last captured value was clamped
//  Busy    out  1             sequencer not in IDLE
// BEHAVIOUR
//  Reset: cnt=0, div=0, state=IDLE, Rx_En=0, Pwm=0, Duty=OFFSET, pend=OFFSET, pend_vld=0, Sat=0.
//  Counter: with En=1, cnt increments and wraps PERIOD-1 -> 0 ("wrap" = cycle cnt==PERIOD-1).
//  div counts wraps 0..SAMPLE_DIV-1.
//  Pwm <= En & (cnt < Duty): high for exactly Duty cycles per period, registered (1-cycle lag).
//  Duty=0 never high; Duty=PERIOD always high.
//  En=0: cnt, div held at 0; Pwm=0; state forced to IDLE; Rx_En=0; pend_vld cleared.
//  Duty and Sat hold their values.
//  FSM:
//   IDLE: on wrap with div==SAMPLE_DIV-1 -> REQ. Trigger arriving when not IDLE is dropped.
//   REQ: Rx_En=1; count RX_EN_CYC cycles, then -> CAPT (Rx_En low from CAPT on).
//   CAPT: latch Yk and compute pend; set pend_vld; update Sat -> IDLE.
//  Arithmetic (width 2*cant_bits+2 signed): v = (Yk >>> SHIFT) + OFFSET.
//   v<DUTY_MIN -> DUTY_MIN, Sat=1; v>DUTY_MAX -> DUTY_MAX, Sat=1; else v[CNT_W-1:0], Sat=0.
//  Apply: on wrap with pend_vld=1, Duty <= pend and pend_vld <= 0.
//   pend_vld set in the same cycle as a wrap applies at the following wrap.
//   Duty never changes mid-period.
//  New capture before apply overwrites pend (latest value wins).
//  Latency: trigger wrap -> Rx_En high next cycle -> CAPT at +RX_EN_CYC+1 -> Duty at next wrap.
//  Rst_G mid-operation: everything returns to reset values immediately; Rx_En drops asynchronously.
//  Busy = (state != IDLE).
// TESTING (PERIOD=20, SAMPLE_DIV=1, RX_EN_CYC=8, SHIFT=4, OFFSET=10, MIN=2, MAX=18)
//  Reset, En=1, Yk=0:
//   Pwm high 10 of every 20 cycles; Rx_En high 8 cycles after each wrap; Duty stays 10, Sat=0.
//  Yk=+64 held:
//   pend=14; Duty 10->14 exactly at the next wrap; Pwm width 14 from that period on.
//  Yk=-32'sd4096: clamps to Duty=2, Sat=1. Then Yk=+4096: Duty=18, Sat=1.
//   Then Yk=16: Duty=11, Sat=0.
//  Yk changes during REQ (value A until CAPT-1, B at CAPT): captured value derives from B only.
//  En dropped mid-REQ: Rx_En=0 and Pwm=0 next cycle, Duty unchanged.
//   En re-raised: cnt restarts at 0, first request after first wrap.
//  Rst_G pulsed mid-period with Duty=14: Pwm, Rx_En =0 at once; Duty=10 after release.
//  SAMPLE_DIV=3: Rx_En asserted after every third wrap only; Duty updates once per 3 periods.

Source files
------------

// File: rtl/pwm_servo_drive.sv
// pwm_servo_drive: sample sequencer, duty conversion and fixed-period PWM for the servo stage.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | waiting for a sample-trigger wrap
//  REQ   | Rx_En held high for RX_EN_CYC cycles
//  CAPT  | Yk latched, saturated duty written to pend
module pwm_servo_drive #(
  parameter int cant_bits  = 16,
  parameter int CNT_W      = 16,
  parameter int PERIOD     = 1000,
  parameter int SAMPLE_DIV = 10,
  parameter int RX_EN_CYC  = 8,
  parameter int SHIFT      = 4,
  parameter int OFFSET     = 500,
  parameter int DUTY_MIN   = 50,
  parameter int DUTY_MAX   = 950
) (
  input  logic                          Clk_G,
  input  logic                          Rst_G,
  input  logic                          En,
  input  logic signed [2*cant_bits-1:0] Yk,
  output logic                          Rx_En,
  output logic                          Pwm,
  output logic [CNT_W-1:0]              Duty,
  output logic                          Sat,
  output logic                          Busy
);

  localparam int YW    = 2 * cant_bits;
  localparam int AW    = 2 * cant_bits + 2;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMR_W = $clog2(RX_EN_CYC);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RX_EN_CYC - 1);
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(OFFSET);
  localparam logic [CNT_W-1:0] DMIN_U   = CNT_W'(DUTY_MIN);
  localparam logic [CNT_W-1:0] DMAX_U   = CNT_W'(DUTY_MAX);
  localparam logic signed [AW-1:0] OFF_S  = AW'(OFFSET);
  localparam logic signed [AW-1:0] DMIN_S = AW'(DUTY_MIN);
  localparam logic signed [AW-1:0] DMAX_S = AW'(DUTY_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DIV_W-1:0]  div;
  logic [TMR_W-1:0]  tmr;
  logic [CNT_W-1:0]  pend;
  logic              pend_vld;
  logic              wrap;
  logic              trig;
  logic signed [AW-1:0] yk_ext;
  logic signed [AW-1:0] v;
  logic [CNT_W-1:0]  v_duty;
  logic              v_sat;

  assign wrap = En && (cnt == CNT_LAST);
  assign trig = wrap && (div == DIV_LAST);
  assign Busy = (state != IDLE);

  // Shift, re-centre and clamp the controller output into a legal duty value.
  always_comb begin
    yk_ext = {{(AW - YW){Yk[YW-1]}}, Yk};
    v      = (yk_ext >>> SHIFT) + OFF_S;
    v_duty = v[CNT_W-1:0];
    v_sat  = 1'b0;
    if (v < DMIN_S) begin
      v_duty = DMIN_U;
      v_sat  = 1'b1;
    end else if (v > DMAX_S) begin
      v_duty = DMAX_U;
      v_sat  = 1'b1;
    end
  end

  // PWM period counter and sample divider; both parked at zero while disabled.
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      cnt <= '0;
      div <= '0;
    end else if (!En) begin
      cnt <= '0;
      div <= '0;
    end else if (wrap) begin
      cnt <= '0;
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sample sequencer plus pending/active duty; a capture landing on a wrap waits one period.
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      state    <= IDLE;
      tmr      <= '0;
      Rx_En    <= 1'b0;
      pend     <= DUTY_RST;
      pend_vld <= 1'b0;
      Duty     <= DUTY_RST;
      Sat      <= 1'b0;
    end else if (!En) begin
      state    <= IDLE;
      tmr      <= '0;
      Rx_En    <= 1'b0;
      pend_vld <= 1'b0;
    end else begin
      if (wrap && pend_vld) begin
        Duty     <= pend;
        pend_vld <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (trig) begin
            state <= REQ;
            Rx_En <= 1'b1;
            tmr   <= TMR_LOAD;
          end
        end
        REQ: begin
          if (tmr == '0) begin
            state <= CAPT;
            Rx_En <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        CAPT: begin
          pend     <= v_duty;
          Sat      <= v_sat;
          pend_vld <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          Rx_En <= 1'b0;
        end
      endcase
    end
  end

  // Registered PWM compare against the duty active for this period.
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      Pwm <= 1'b0;
    end else begin
      Pwm <= En && (cnt < Duty);
    end
  end

endmodule

// File: tb/tb_pwm_servo_drive.sv
// tb_pwm_servo_drive: scoreboard bench for the servo PWM drive (period 20, two divider settings).
module tb_pwm_servo_drive;

  localparam int P = 20;

  typedef struct {
    int duty;
    int sat;
  } exp_t;

  logic               Clk_G = 1'b0;
  logic               Rst_G;
  logic               En;
  logic signed [31:0] Yk;
  logic               rx1, pwm1, sat1, busy1;
  logic               rx2, pwm2, sat2, busy2;
  logic [15:0]        duty1, duty2;

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_d1 = 10, exp_s1 = 0;
  int   exp_d2 = 10, exp_s2 = 0;
  exp_t q1[$];
  exp_t q2[$];
  int   ya[$];
  int   yb[$];

  pwm_servo_drive #(
    .cant_bits(16), .CNT_W(16), .PERIOD(P), .SAMPLE_DIV(1), .RX_EN_CYC(8),
    .SHIFT(4), .OFFSET(10), .DUTY_MIN(2), .DUTY_MAX(18)
  ) dut1 (
    .Clk_G(Clk_G), .Rst_G(Rst_G), .En(En), .Yk(Yk),
    .Rx_En(rx1), .Pwm(pwm1), .Duty(duty1), .Sat(sat1), .Busy(busy1)
  );

  pwm_servo_drive #(
    .cant_bits(16), .CNT_W(16), .PERIOD(P), .SAMPLE_DIV(3), .RX_EN_CYC(8),
    .SHIFT(4), .OFFSET(10), .DUTY_MIN(2), .DUTY_MAX(18)
  ) dut2 (
    .Clk_G(Clk_G), .Rst_G(Rst_G), .En(En), .Yk(Yk),
    .Rx_En(rx2), .Pwm(pwm2), .Duty(duty2), .Sat(sat2), .Busy(busy2)
  );

  always #5 Clk_G = ~Clk_G;

  task automatic chk(input string tag, input longint got, input longint want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge Clk_G);
    #1;
  endtask

  // Expected duty/sat for a captured controller value (shift 4, centre 10, clamp 2..18).
  function automatic exp_t model(input int yk);
    exp_t   e;
    longint v;
    v = (longint'(yk) >>> 4) + 64'sd10;
    if (v < 2) begin
      e.duty = 2;  e.sat = 1;
    end else if (v > 18) begin
      e.duty = 18; e.sat = 1;
    end else begin
      e.duty = int'(v); e.sat = 0;
    end
    return e;
  endfunction

  // Runs n full periods starting at a cnt==0 cycle; Yk=A for cnt 0..7, B from cnt 8 (CAPT).
  task automatic run_periods(input int n);
    exp_t e;
    int   a, b, pw1, pw2, rc1, rc2, bz;
    for (int p = 0; p <= n; p++) begin
      if (q1.size() > 0) begin
        e = q1.pop_front();
        exp_d1 = e.duty;
        exp_s1 = e.sat;
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        exp_d2 = e.duty;
        exp_s2 = e.sat;
      end
      chk("duty1", duty1, exp_d1);
      chk("sat1", sat1, exp_s1);
      chk("duty2", duty2, exp_d2);
      chk("sat2", sat2, exp_s2);
      if (p == n) return;
      a  = ya.pop_front();
      b  = yb.pop_front();
      Yk = a;
      if (p >= 1) q1.push_back(model(b));
      if (p >= 3 && p % 3 == 0) q2.push_back(model(b));
      pw1 = 0; pw2 = 0; rc1 = 0; rc2 = 0; bz = 0;
      for (int k = 0; k < P; k++) begin
        rc1 += int'(rx1);
        rc2 += int'(rx2);
        bz  += int'(busy1);
        if (k == 8) Yk = b;
        tick();
        pw1 += int'(pwm1);
        pw2 += int'(pwm2);
      end
      chk("pwm1_width", pw1, exp_d1);
      chk("pwm2_width", pw2, exp_d2);
      chk("rx1_len", rc1, (p >= 1) ? 8 : 0);
      chk("rx2_len", rc2, (p >= 3 && p % 3 == 0) ? 8 : 0);
      chk("busy1_len", bz, (p >= 1) ? 9 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_G = 1'b1;
    En    = 1'b0;
    Yk    = '0;
    repeat (3) tick();
    chk("rst_pwm", pwm1, 0);
    chk("rst_rx", rx1, 0);
    chk("rst_duty", duty1, 10);
    chk("rst_sat", sat1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_duty2", duty2, 10);

    Rst_G = 1'b0;
    En    = 1'b1;
    ya = '{0, 0, 64, 64, -4096, 4096, 16, 4096, 100, -100, -128, 128, -144, -1, 10};
    yb = '{0, 0, 64, 64, -4096, 4096, 16, -32,  100, -100, -128, 128, -144, -1, 10};
    run_periods(15);

    // Drop En while dut1 is mid-request.
    repeat (3) tick();
    chk("rx1_before_drop", rx1, 1);
    En = 1'b0;
    tick();
    chk("drop_rx1", rx1, 0);
    chk("drop_pwm1", pwm1, 0);
    chk("drop_busy1", busy1, 0);
    chk("drop_duty1", duty1, exp_d1);
    repeat (4) tick();
    chk("idle_pwm1", pwm1, 0);
    chk("idle_rx1", rx1, 0);
    q1.delete();
    q2.delete();

    En = 1'b1;
    ya = '{999, -1, 64, 128, 64};
    yb = '{999, -1, 64, 128, 64};
    run_periods(5);

    // Async reset mid-period with Duty=14 and a request in flight.
    repeat (3) tick();
    chk("pre_rst_pwm1", pwm1, 1);
    chk("pre_rst_rx1", rx1, 1);
    Rst_G = 1'b1;
    #1;
    chk("async_rst_pwm1", pwm1, 0);
    chk("async_rst_rx1", rx1, 0);
    chk("async_rst_busy1", busy1, 0);
    tick();
    Rst_G = 1'b0;
    tick();
    chk("post_rst_duty1", duty1, 10);
    chk("post_rst_sat1", sat1, 0);
    chk("post_rst_duty2", duty2, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
